updown_value_monitor: RTL

//   Downstream consumer of the up/down counter's 32-bit value output.

---
 rtl/updown_value_monitor.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/updown_value_monitor.sv
// updown_value_monitor
//   Watches the 32-bit value of an up/down counter. Every valid sample:
//   - updates the running unsigned min/max since reset/clear,
//   - flags wrap-around (all-ones -> 0 is an up-wrap, 0 -> all-ones is a
//     down-wrap) and keeps a modular signed net wrap count,
//   - runs debounced, hysteretic high/low threshold alarms through a
//     4-state FSM (INIT, NORMAL, HIGH, LOW).
//   All outputs are registered, so they show the effect of a sample one
//   edge after it is presented.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-high reset (highest priority)
//   value          counter value to monitor
//   value_valid    sample value at this edge; when low everything holds
//   clear          synchronous clear of statistics and alarms
//   state          00 INIT, 01 NORMAL, 10 HIGH, 11 LOW
//   alarm_hi       high while state is HIGH
//   alarm_lo       high while state is LOW
//   wrap_up_pulse  one-cycle pulse after an all-ones -> 0 sample pair
//   wrap_dn_pulse  one-cycle pulse after a 0 -> all-ones sample pair
//   wrap_count     net wraps (+1 up, -1 down), two's complement, modular
//   min_value      smallest unsigned sample since reset/clear
//   max_value      largest unsigned sample since reset/clear
module updown_value_monitor #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  HI_THRESH = 32'hF000_0000,
  parameter logic [WIDTH-1:0]  LO_THRESH = 32'h0000_1000,
  parameter int unsigned       HYST      = 16,
  parameter int unsigned       DEBOUNCE  = 4,
  parameter int unsigned       WRAPW     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             value_valid,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             alarm_hi,
  output logic             alarm_lo,
  output logic             wrap_up_pulse,
  output logic             wrap_dn_pulse,
  output logic [WRAPW-1:0] wrap_count,
  output logic [WIDTH-1:0] min_value,
  output logic [WIDTH-1:0] max_value
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_NORMAL = 2'b01,
    ST_HIGH   = 2'b10,
    ST_LOW    = 2'b11
  } state_t;

  localparam int unsigned      CNTW    = $clog2(DEBOUNCE + 1);
  localparam logic [CNTW-1:0]  DEB_MAX = CNTW'(DEBOUNCE);
  localparam logic [WIDTH:0]   HYST_X  = (WIDTH+1)'(HYST);
  // Exit levels computed one bit wider so an overflowing parameter set is
  // caught below instead of silently wrapping.
  localparam logic [WIDTH:0]   LO_EXIT_X = {1'b0, LO_THRESH} + HYST_X;
  localparam logic [WIDTH:0]   HI_EXIT_X = {1'b0, HI_THRESH} - HYST_X;
  localparam logic [WIDTH-1:0] LO_EXIT   = LO_EXIT_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] HI_EXIT   = HI_EXIT_X[WIDTH-1:0];
  localparam bit PARAMS_OK = (DEBOUNCE >= 1) && ({1'b0, HI_THRESH} >= HYST_X) &&
                             (LO_EXIT_X < HI_EXIT_X);

  if (!PARAMS_OK) begin : g_bad_params
    $error("updown_value_monitor: need DEBOUNCE>=1 and LO_THRESH+HYST < HI_THRESH-HYST");
  end

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] prev_r, prev_nxt_s;
  logic             prev_valid_r, prev_valid_nxt_s;
  logic [CNTW-1:0]  hi_cnt_r, hi_cnt_nxt_s;
  logic [CNTW-1:0]  lo_cnt_r, lo_cnt_nxt_s;
  logic [WIDTH-1:0] min_r, min_nxt_s;
  logic [WIDTH-1:0] max_r, max_nxt_s;
  logic [WRAPW-1:0] wrap_count_r, wrap_count_nxt_s;
  logic             up_pulse_r, up_pulse_nxt_s;
  logic             dn_pulse_r, dn_pulse_nxt_s;
  logic             alarm_hi_r, alarm_lo_r;

  // Next-state computation for the FSM, statistics, wrap detection and debounce.
  always_comb begin
    state_nxt_s      = state_r;
    prev_nxt_s       = prev_r;
    prev_valid_nxt_s = prev_valid_r;
    hi_cnt_nxt_s     = hi_cnt_r;
    lo_cnt_nxt_s     = lo_cnt_r;
    min_nxt_s        = min_r;
    max_nxt_s        = max_r;
    wrap_count_nxt_s = wrap_count_r;
    up_pulse_nxt_s   = 1'b0;
    dn_pulse_nxt_s   = 1'b0;

    if (value_valid) begin
      prev_nxt_s       = value;
      prev_valid_nxt_s = 1'b1;

      // Saturating run-length counters; any out-of-band sample restarts them.
      if (value >= HI_THRESH) begin
        hi_cnt_nxt_s = (hi_cnt_r == DEB_MAX) ? hi_cnt_r : hi_cnt_r + CNTW'(1);
      end else begin
        hi_cnt_nxt_s = {CNTW{1'b0}};
      end
      if (value <= LO_THRESH) begin
        lo_cnt_nxt_s = (lo_cnt_r == DEB_MAX) ? lo_cnt_r : lo_cnt_r + CNTW'(1);
      end else begin
        lo_cnt_nxt_s = {CNTW{1'b0}};
      end

      if (state_r == ST_INIT) begin
        min_nxt_s = value;
        max_nxt_s = value;
      end else begin
        min_nxt_s = (value < min_r) ? value : min_r;
        max_nxt_s = (value > max_r) ? value : max_r;
      end

      // The first sample after reset/clear has no predecessor to wrap from.
      if (prev_valid_r && (prev_r == ALL_ONES) && (value == ALL_ZERO)) begin
        up_pulse_nxt_s   = 1'b1;
        wrap_count_nxt_s = wrap_count_r + WRAPW'(1);
      end else if (prev_valid_r && (prev_r == ALL_ZERO) && (value == ALL_ONES)) begin
        dn_pulse_nxt_s   = 1'b1;
        wrap_count_nxt_s = wrap_count_r - WRAPW'(1);
      end else begin
        wrap_count_nxt_s = wrap_count_r;
      end

      case (state_r)
        ST_INIT: begin
          state_nxt_s = ST_NORMAL;
        end
        ST_NORMAL: begin
          if (hi_cnt_nxt_s == DEB_MAX) begin
            state_nxt_s = ST_HIGH;
          end else if (lo_cnt_nxt_s == DEB_MAX) begin
            state_nxt_s = ST_LOW;
          end else begin
            state_nxt_s = ST_NORMAL;
          end
        end
        ST_HIGH: begin
          state_nxt_s = (value < HI_EXIT) ? ST_NORMAL : ST_HIGH;
        end
        ST_LOW: begin
          state_nxt_s = (value > LO_EXIT) ? ST_NORMAL : ST_LOW;
        end
        default: begin
          state_nxt_s = ST_INIT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers; reset and clear both restore the idle values.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_r      <= ST_INIT;
      prev_r       <= ALL_ZERO;
      prev_valid_r <= 1'b0;
      hi_cnt_r     <= {CNTW{1'b0}};
      lo_cnt_r     <= {CNTW{1'b0}};
      min_r        <= ALL_ONES;
      max_r        <= ALL_ZERO;
      wrap_count_r <= {WRAPW{1'b0}};
      up_pulse_r   <= 1'b0;
      dn_pulse_r   <= 1'b0;
      alarm_hi_r   <= 1'b0;
      alarm_lo_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_r       <= prev_nxt_s;
      prev_valid_r <= prev_valid_nxt_s;
      hi_cnt_r     <= hi_cnt_nxt_s;
      lo_cnt_r     <= lo_cnt_nxt_s;
      min_r        <= min_nxt_s;
      max_r        <= max_nxt_s;
      wrap_count_r <= wrap_count_nxt_s;
      up_pulse_r   <= up_pulse_nxt_s;
      dn_pulse_r   <= dn_pulse_nxt_s;
      alarm_hi_r   <= (state_nxt_s == ST_HIGH);
      alarm_lo_r   <= (state_nxt_s == ST_LOW);
    end
  end

  assign state         = state_r;
  assign alarm_hi      = alarm_hi_r;
  assign alarm_lo      = alarm_lo_r;
  assign wrap_up_pulse = up_pulse_r;
  assign wrap_dn_pulse = dn_pulse_r;
  assign wrap_count    = wrap_count_r;
  assign min_value     = min_r;
  assign max_value     = max_r;

endmodule
